xrbus_tx_assembler: RTL and testbench
=====================================

XRBUS_TX_ASSEMBLER -- requirements
Module: xrbus_tx_assembler

Interface
REQ-001 Parameter MAX_WORDS, default 32, SHALL set the maximum number of payload words per frame (32 x 32 bits = 1024-bit payload).
REQ-002 Parameter BUSY_TIMEOUT, default 1024, SHALL set the number of device_clk cycles to wait for bus_busy low before abort.
REQ-003 device_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 s_valid  in  1  source beat valid.
REQ-006 s_ready  out  1  block accepts beat; a beat transfers when s_valid and s_ready are both high.
REQ-007 s_data  in  32  payload word.
REQ-008 s_last  in  1  final beat of frame.
REQ-009 s_module_id  in  16, s_boundary_id  in  16, s_op_code  in  8  header fields, sampled on a frame's first beat only.
REQ-010 bus_busy  in  1  downstream XR-BUS busy status.
REQ-011 module_id  out  16, boundary_id  out  16, op_code  out  8  latched header to the bus.
REQ-012 payload  out  1024  assembled payload; word k occupies bits [32k+31:32k].
REQ-013 payload_len  out  10  payload length in bytes.
REQ-014 tx_request  out  1  one-cycle frame-issue strobe.
REQ-015 err_overflow  out  1, err_timeout  out  1  one-cycle error pulses.
REQ-016 frame_count  out  16  count of issued frames.

Function
REQ-017 The FSM SHALL have states IDLE, COLLECT, DRAIN, ISSUE and WAIT_BUSY.
REQ-018 s_ready SHALL be high in IDLE, COLLECT and DRAIN, and low in ISSUE and WAIT_BUSY.
REQ-019 On a beat in IDLE, the block SHALL latch the header, clear payload, write s_data to word 0 and set word count to 1; it SHALL go to ISSUE if s_last is high, otherwise to COLLECT.
REQ-020 In COLLECT, each beat SHALL write word[count] and increment count; s_last SHALL move the FSM to ISSUE.
REQ-021 In COLLECT, a beat arriving with count equal to MAX_WORDS SHALL be discarded and SHALL pulse err_overflow once; the FSM SHALL go to DRAIN, or to ISSUE if that beat carries s_last.
REQ-022 DRAIN SHALL discard beats until one with s_last is accepted, then go to ISSUE.
REQ-023 payload_len SHALL equal count x 4, with a maximum of 128; unwritten words SHALL read zero.
REQ-024 ISSUE SHALL assert tx_request for exactly one cycle, increment frame_count (wrapping FFFF to 0000), and go to WAIT_BUSY.
REQ-025 Latency: if the last beat is accepted at edge N, tx_request SHALL be high during the cycle following edge N.
REQ-026 WAIT_BUSY SHALL return to IDLE at the first cycle in which bus_busy is low, checked from the cycle after ISSUE onward.
REQ-027 WAIT_BUSY SHALL count cycles with bus_busy high; on reaching BUSY_TIMEOUT it SHALL pulse err_timeout and return to IDLE.
REQ-028 module_id, boundary_id, op_code, payload and payload_len SHALL stay stable from ISSUE until the next frame's first beat is accepted.
REQ-029 A frame of exactly MAX_WORDS beats with s_last on beat 32 SHALL NOT flag overflow.
REQ-030 s_valid low mid-frame SHALL stall assembly indefinitely with no timeout.

Reset
REQ-031 While rst_n is low: state IDLE, all outputs 0 (including s_ready, payload and frame_count), counters 0.
REQ-032 s_ready SHALL be registered, reset to 0, and go high at the first device_clk edge after rst_n deasserts.
REQ-033 A reset mid-frame SHALL discard the partial frame and SHALL NOT produce tx_request.

Structure
REQ-034 Shared package xrbus_pkg SHALL hold the FSM state enum, XRBUS_WORD_W=32 and XRBUS_PAYLOAD_W=1024.
REQ-035 The block SHALL be a single module with no sub-modules; the timeout counter and word counter are inline.

Verification
REQ-036 Single beat 0xDEADBEEF, s_last=1, op_code 0x11 -> tx_request one cycle later, payload[31:0]=DEADBEEF, upper bits 0, payload_len=4, frame_count=1.
REQ-037 Three beats A0/A1/A2 with a 2-cycle s_valid gap -> payload words 0..2 = A0,A1,A2, payload_len=12, exactly one tx_request.
REQ-038 34 beats, last on beat 34 -> err_overflow pulses on beat 33 only, payload_len=128, words 0..31 are beats 1..32, one tx_request.
REQ-039 bus_busy held high 1024 cycles after ISSUE -> err_timeout pulse, s_ready high the next cycle; bus_busy low after 5 cycles -> no error, s_ready returns to 1.
REQ-040 rst_n asserted after 2 of 4 beats -> no tx_request, all outputs 0; a new 1-beat frame afterward issues normally with frame_count=1.

Source files
------------

// File: rtl/xrbus_pkg.sv
// Shared XR-BUS transmit types: word/payload widths and the assembler FSM state encoding.
package xrbus_pkg;

  localparam int XRBUS_WORD_W    = 32;
  localparam int XRBUS_PAYLOAD_W = 1024;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DRAIN,
    ISSUE,
    WAIT_BUSY
  } xrbus_tx_state_e;

endpackage

// File: rtl/xrbus_tx_assembler.sv
// Collects a beat stream into one XR-BUS frame and issues a one-cycle tx_request the cycle after the last beat.
// s_ready is registered and drops from ISSUE until the bus frees up (or the busy timeout fires).
module xrbus_tx_assembler
  import xrbus_pkg::*;
#(
  parameter int MAX_WORDS    = 32,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic                       device_clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [XRBUS_WORD_W-1:0]    s_data,
  input  logic                       s_last,
  input  logic [15:0]                s_module_id,
  input  logic [15:0]                s_boundary_id,
  input  logic [7:0]                 s_op_code,
  input  logic                       bus_busy,
  output logic [15:0]                module_id,
  output logic [15:0]                boundary_id,
  output logic [7:0]                 op_code,
  output logic [XRBUS_PAYLOAD_W-1:0] payload,
  output logic [9:0]                 payload_len,
  output logic                       tx_request,
  output logic                       err_overflow,
  output logic                       err_timeout,
  output logic [15:0]                frame_count
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  xrbus_tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [XRBUS_PAYLOAD_W-1:0] payload_q, payload_d;
  logic [15:0]                mod_q, mod_d, bnd_q, bnd_d, fcnt_q, fcnt_d;
  logic [7:0]                 op_q, op_d;
  logic                       rdy_q, rdy_d, txreq_q, txreq_d;
  logic                       ovf_q, ovf_d, tmo_err_q, tmo_err_d;
  logic                       beat;

  assign beat = s_valid && rdy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = '0;
    payload_d = payload_q;
    mod_d     = mod_q;
    bnd_d     = bnd_q;
    op_d      = op_q;
    ovf_d     = 1'b0;
    tmo_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          mod_d     = s_module_id;
          bnd_d     = s_boundary_id;
          op_d      = s_op_code;
          payload_d = '0;
          payload_d[XRBUS_WORD_W-1:0] = s_data;
          cnt_d     = CNT_W'(1);
          state_d   = s_last ? ISSUE : COLLECT;
        end
      end
      COLLECT: begin
        if (beat) begin
          // A full frame drops the extra beat and drains the rest of the source frame.
          if (cnt_q == CNT_W'(MAX_WORDS)) begin
            ovf_d   = 1'b1;
            state_d = s_last ? ISSUE : DRAIN;
          end else begin
            for (int w = 0; w < MAX_WORDS; w++) begin
              if (cnt_q == CNT_W'(w)) payload_d[w*XRBUS_WORD_W +: XRBUS_WORD_W] = s_data;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (s_last) state_d = ISSUE;
          end
        end
      end
      DRAIN: begin
        if (beat && s_last) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus_busy) begin
          state_d = IDLE;
        end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    txreq_d = (state_d == ISSUE);
    fcnt_d  = txreq_d ? fcnt_q + 16'd1 : fcnt_q;
    rdy_d   = state_d inside {IDLE, COLLECT, DRAIN};
  end

  always_ff @(posedge device_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      payload_q <= '0;
      mod_q     <= '0;
      bnd_q     <= '0;
      op_q      <= '0;
      fcnt_q    <= '0;
      rdy_q     <= 1'b0;
      txreq_q   <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      payload_q <= payload_d;
      mod_q     <= mod_d;
      bnd_q     <= bnd_d;
      op_q      <= op_d;
      fcnt_q    <= fcnt_d;
      rdy_q     <= rdy_d;
      txreq_q   <= txreq_d;
      ovf_q     <= ovf_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign s_ready      = rdy_q;
  assign module_id    = mod_q;
  assign boundary_id  = bnd_q;
  assign op_code      = op_q;
  assign payload      = payload_q;
  assign payload_len  = 10'({cnt_q, 2'b00});
  assign tx_request   = txreq_q;
  assign err_overflow = ovf_q;
  assign err_timeout  = tmo_err_q;
  assign frame_count  = fcnt_q;

endmodule

// File: tb/tb_xrbus_tx_assembler.sv
// Bench for xrbus_tx_assembler: table of frames scored against a queue of expected frames,
// plus hand-written busy-timeout and mid-frame reset sequences.
module tb_xrbus_tx_assembler;

  logic          device_clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, s_last, bus_busy;
  logic [31:0]   s_data;
  logic [15:0]   s_module_id, s_boundary_id;
  logic [7:0]    s_op_code;
  logic [15:0]   module_id, boundary_id, frame_count;
  logic [7:0]    op_code;
  logic [1023:0] payload;
  logic [9:0]    payload_len;
  logic          tx_request, err_overflow, err_timeout;

  xrbus_tx_assembler dut (
    .device_clk   (device_clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_module_id  (s_module_id),
    .s_boundary_id(s_boundary_id),
    .s_op_code    (s_op_code),
    .bus_busy     (bus_busy),
    .module_id    (module_id),
    .boundary_id  (boundary_id),
    .op_code      (op_code),
    .payload      (payload),
    .payload_len  (payload_len),
    .tx_request   (tx_request),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout),
    .frame_count  (frame_count)
  );

  always #5 device_clk = ~device_clk;

  typedef struct {
    int          nbeats;
    int          gap;
    logic [31:0] base;
    logic [15:0] mod;
    logic [15:0] bnd;
    logic [7:0]  op;
    int          exp_ovf;
  } vec_t;

  typedef struct {
    logic [1023:0] payload;
    logic [9:0]    len;
    logic [15:0]   mod;
    logic [15:0]   bnd;
    logic [7:0]    op;
    logic [15:0]   fcnt;
  } exp_frame_t;

  exp_frame_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int exp_fcnt = 0;
  int ovf_pulses = 0;
  int tmo_pulses = 0;
  int txreq_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge, and score any issued frame.
  task automatic tick();
    exp_frame_t e;
    @(posedge device_clk);
    #1;
    if (err_overflow) ovf_pulses++;
    if (err_timeout) tmo_pulses++;
    if (tx_request) begin
      txreq_pulses++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_tx: got tx_request=1 expected no frame pending");
      end else begin
        e = exp_q.pop_front();
        chk("sb_module_id", 32'(module_id), 32'(e.mod));
        chk("sb_boundary_id", 32'(boundary_id), 32'(e.bnd));
        chk("sb_op_code", 32'(op_code), 32'(e.op));
        chk("sb_payload_len", 32'(payload_len), 32'(e.len));
        chk("sb_frame_count", 32'(frame_count), 32'(e.fcnt));
        for (int w = 0; w < 32; w++)
          chk($sformatf("sb_word%0d", w), payload[32*w +: 32], e.payload[32*w +: 32]);
      end
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [15:0] mid,
                           input logic [15:0] bid, input logic [7:0] op);
    int waited = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    s_module_id = mid;
    s_boundary_id = bid;
    s_op_code = op;
    while (!s_ready && waited < 2000) begin
      tick();
      waited++;
    end
    if (!s_ready) chk("beat_ready_wait", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic push_exp(input vec_t v, output exp_frame_t e);
    int nw;
    nw = (v.nbeats > 32) ? 32 : v.nbeats;
    e.payload = '0;
    for (int k = 0; k < nw; k++) e.payload[32*k +: 32] = v.base + 32'(k);
    e.len = 10'(nw * 4);
    e.mod = v.mod;
    e.bnd = v.bnd;
    e.op = v.op;
    exp_fcnt = (exp_fcnt + 1) % 65536;
    e.fcnt = 16'(exp_fcnt);
    exp_q.push_back(e);
  endtask

  // Header fields on non-first beats are scrambled: only the first beat's header may be latched.
  task automatic drive_frame(input vec_t v);
    for (int k = 0; k < v.nbeats; k++) begin
      if (k == 0) send_beat(v.base, v.nbeats == 1, v.mod, v.bnd, v.op);
      else send_beat(v.base + 32'(k), k == v.nbeats - 1, ~v.mod, ~v.bnd, ~v.op);
      if (k != v.nbeats - 1) repeat (v.gap) tick();
    end
    chk("tx_latency", 32'(tx_request), 32'd1);
    chk("ready_low_in_issue", 32'(s_ready), 32'd0);
  endtask

  task automatic send_frame(input vec_t v);
    exp_frame_t e;
    int tx0 = txreq_pulses;
    int ov0 = ovf_pulses;
    push_exp(v, e);
    drive_frame(v);
    repeat (3) tick();
    chk("payload_len_hold", 32'(payload_len), 32'(e.len));
    chk("ready_back", 32'(s_ready), 32'd1);
    chk("tx_once", 32'(txreq_pulses - tx0), 32'd1);
    chk("ovf_pulses", 32'(ovf_pulses - ov0), 32'(v.exp_ovf));
  endtask

  vec_t vecs[6];

  initial begin
    exp_frame_t e;
    vec_t hv;
    int i, tx0, tm0;
    bit found;

    vecs[0] = '{nbeats: 1,  gap: 0, base: 32'hDEADBEEF, mod: 16'h0101, bnd: 16'h0202, op: 8'h11, exp_ovf: 0};
    vecs[1] = '{nbeats: 3,  gap: 2, base: 32'h000000A0, mod: 16'h1234, bnd: 16'h5678, op: 8'h22, exp_ovf: 0};
    vecs[2] = '{nbeats: 32, gap: 0, base: 32'h10000000, mod: 16'hAAAA, bnd: 16'h5555, op: 8'h33, exp_ovf: 0};
    vecs[3] = '{nbeats: 34, gap: 0, base: 32'h20000000, mod: 16'hBEEF, bnd: 16'hCAFE, op: 8'h44, exp_ovf: 1};
    vecs[4] = '{nbeats: 33, gap: 1, base: 32'h30000000, mod: 16'h0F0F, bnd: 16'hF0F0, op: 8'h55, exp_ovf: 1};
    vecs[5] = '{nbeats: 5,  gap: 1, base: 32'h40000000, mod: 16'h7777, bnd: 16'h8888, op: 8'h66, exp_ovf: 0};

    rst_n = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
    s_module_id = '0;
    s_boundary_id = '0;
    s_op_code = '0;
    bus_busy = 1'b0;
    repeat (2) tick();
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_payload_len", 32'(payload_len), 32'd0);
    chk("rst_payload_zero", 32'(|payload), 32'd0);
    chk("rst_tx_request", 32'(tx_request), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 32'(s_ready), 32'd1);

    for (int v = 0; v < 6; v++) send_frame(vecs[v]);

    // Bus held busy past the timeout.
    hv = '{nbeats: 1, gap: 0, base: 32'h50000000, mod: 16'h1111, bnd: 16'h2222, op: 8'h77, exp_ovf: 0};
    bus_busy = 1'b1;
    tm0 = tmo_pulses;
    push_exp(hv, e);
    drive_frame(hv);
    i = 0;
    found = 1'b0;
    while (i < 1100 && !found) begin
      tick();
      i++;
      if (err_timeout) found = 1'b1;
    end
    chk("timeout_cycles", 32'(i), 32'd1025);
    chk("timeout_ready", 32'(s_ready), 32'd1);
    bus_busy = 1'b0;
    tick();
    chk("timeout_one_cycle", 32'(err_timeout), 32'd0);
    chk("timeout_pulses", 32'(tmo_pulses - tm0), 32'd1);

    // Bus busy for five cycles only.
    hv = '{nbeats: 2, gap: 0, base: 32'h60000000, mod: 16'h3333, bnd: 16'h4444, op: 8'h88, exp_ovf: 0};
    bus_busy = 1'b1;
    tm0 = tmo_pulses;
    push_exp(hv, e);
    drive_frame(hv);
    repeat (5) tick();
    chk("busy_ready_low", 32'(s_ready), 32'd0);
    bus_busy = 1'b0;
    tick();
    chk("busy_release_ready", 32'(s_ready), 32'd1);
    repeat (2) tick();
    chk("busy_no_timeout", 32'(tmo_pulses - tm0), 32'd0);

    // Reset after two of four beats.
    tx0 = txreq_pulses;
    send_beat(32'h70000000, 1'b0, 16'h9999, 16'hAAAA, 8'h99);
    send_beat(32'h70000001, 1'b0, 16'h9999, 16'hAAAA, 8'h99);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(s_ready), 32'd0);
    chk("midrst_frame_count", 32'(frame_count), 32'd0);
    chk("midrst_payload_zero", 32'(|payload), 32'd0);
    chk("midrst_payload_len", 32'(payload_len), 32'd0);
    chk("midrst_module_id", 32'(module_id), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    exp_fcnt = 0;
    tick();
    repeat (3) tick();
    chk("midrst_no_tx", 32'(txreq_pulses - tx0), 32'd0);
    hv = '{nbeats: 1, gap: 0, base: 32'h80000000, mod: 16'h5A5A, bnd: 16'hA5A5, op: 8'hAB, exp_ovf: 0};
    send_frame(hv);
    chk("midrst_frame_count_one", 32'(frame_count), 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
